// File: rtl/ctx_pkg.sv
// Shared types and sizes for the context save/restore sequencer.
package ctx_pkg;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    SAVE_DONE,
    RESTORE,
    RESTORE_DONE
  } state_t;
endpackage

// File: rtl/ctx_stack.sv
// Frame storage: DEPTH frames of NUM_REGS registers, sync write, comb read.
module ctx_stack
  import ctx_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int FW    = 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [FW-1:0]    wr_frame,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic [FW-1:0]    rd_frame,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data
);
  logic [DW-1:0] mem [DEPTH][NUM_REGS];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_frame][wr_idx] <= wr_data;

  assign rd_data = mem[rd_frame][rd_idx];
endmodule

// File: rtl/ctx_save_sequencer.sv
// Saves R0..R3 into a LIFO frame stack on irq and writes them back on iret,
// borrowing the register-file ports from the CPU while it works.
module ctx_save_sequencer
  import ctx_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       irq_req,
  input  logic                       iret_req,
  input  logic [1:0]                 cpu_rd1_idx,
  input  logic [1:0]                 cpu_rd2_idx,
  input  logic [1:0]                 cpu_wr_idx,
  input  logic                       cpu_wr_en,
  input  logic [DW-1:0]              cpu_wr_data,
  output logic [1:0]                 rf_rd1_idx,
  output logic [1:0]                 rf_rd2_idx,
  output logic [1:0]                 rf_wr_idx,
  output logic                       rf_wr_en,
  output logic [DW-1:0]              rf_wr_data,
  input  logic [DW-1:0]              rf_rd1_data,
  output logic                       busy,
  output logic                       irq_ack,
  output logic                       iret_ack,
  output logic                       iret_err,
  output logic                       stack_full,
  output logic [$clog2(DEPTH+1)-1:0] depth
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int FW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_REGS - 1);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [SPW-1:0]   sp;
  logic [DW-1:0]    stk_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      sp       <= '0;
      busy     <= 1'b0;
      irq_ack  <= 1'b0;
      iret_ack <= 1'b0;
      iret_err <= 1'b0;
    end else begin
      irq_ack  <= 1'b0;
      iret_ack <= 1'b0;
      iret_err <= 1'b0;
      case (state)
        IDLE: begin
          k <= '0;
          // iret wins over irq; an irq against a full stack simply waits
          if (iret_req) begin
            if (sp != '0) begin
              state <= RESTORE;
              busy  <= 1'b1;
            end else begin
              iret_err <= 1'b1;
            end
          end else if (irq_req && sp != SPW'(DEPTH)) begin
            state <= SAVE;
            busy  <= 1'b1;
          end
        end
        SAVE: begin
          k <= k + IDX_W'(1);
          if (k == K_LAST) begin
            state   <= SAVE_DONE;
            irq_ack <= 1'b1;
          end
        end
        SAVE_DONE: begin
          sp    <= sp + SPW'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        RESTORE: begin
          k <= k + IDX_W'(1);
          if (k == K_LAST) begin
            state    <= RESTORE_DONE;
            iret_ack <= 1'b1;
          end
        end
        RESTORE_DONE: begin
          sp    <= sp - SPW'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stack_full = (sp == SPW'(DEPTH));
  assign depth      = sp;

  always_comb begin
    rf_rd1_idx = cpu_rd1_idx;
    rf_rd2_idx = cpu_rd2_idx;
    rf_wr_idx  = cpu_wr_idx;
    rf_wr_en   = cpu_wr_en && (state == IDLE);
    rf_wr_data = cpu_wr_data;
    if (state == SAVE) rf_rd1_idx = k;
    if (state == RESTORE) begin
      rf_wr_en   = 1'b1;
      rf_wr_idx  = k;
      rf_wr_data = stk_rd_data;
    end
  end

  ctx_stack #(.DEPTH(DEPTH), .DW(DW), .FW(FW)) u_stack (
    .clk      (clk),
    .wr_en    (state == SAVE),
    .wr_frame (FW'(sp)),
    .wr_idx   (k),
    .wr_data  (rf_rd1_data),
    .rd_frame (FW'(sp - SPW'(1))),
    .rd_idx   (k),
    .rd_data  (stk_rd_data)
  );
endmodule

// File: tb/tb_ctx_save_sequencer.sv
// Scoreboard bench: saved frames are pushed when an irq is issued and popped
// (LIFO) against the register file model when the matching iret completes.
module tb_ctx_save_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       irq_req, iret_req;
  logic [1:0] cpu_rd1_idx, cpu_rd2_idx, cpu_wr_idx;
  logic       cpu_wr_en;
  logic [7:0] cpu_wr_data;
  logic [1:0] rf_rd1_idx, rf_rd2_idx, rf_wr_idx;
  logic       rf_wr_en;
  logic [7:0] rf_wr_data, rf_rd1_data;
  logic       busy, irq_ack, iret_ack, iret_err, stack_full;
  logic [1:0] depth;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] cur;
  logic [7:0]  rf [4];

  always #5 clk = ~clk;

  assign rf_rd1_data = rf[rf_rd1_idx];
  always @(posedge clk) if (rf_wr_en) begin
    rf[rf_wr_idx] <= rf_wr_data;
    wr_cnt <= wr_cnt + 1;
  end

  ctx_save_sequencer #(.DEPTH(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .iret_req(iret_req),
    .cpu_rd1_idx(cpu_rd1_idx), .cpu_rd2_idx(cpu_rd2_idx), .cpu_wr_idx(cpu_wr_idx),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
    .rf_rd1_idx(rf_rd1_idx), .rf_rd2_idx(rf_rd2_idx), .rf_wr_idx(rf_wr_idx),
    .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data), .rf_rd1_data(rf_rd1_data),
    .busy(busy), .irq_ack(irq_ack), .iret_ack(iret_ack), .iret_err(iret_err),
    .stack_full(stack_full), .depth(depth)
  );

  function automatic logic [31:0] rf_pack();
    return {rf[3], rf[2], rf[1], rf[0]};
  endfunction

  task automatic load4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_wr_en = 1'b1; cpu_wr_idx = 2'(i); cpu_wr_data = v[8*i +: 8];
    end
    @(negedge clk);
    cpu_wr_en = 1'b0;
    cur = v;
  endtask

  task automatic do_save(input logic [1:0] exp_depth);
    int lat = 0;
    bit bz = 1'b1;
    @(negedge clk); irq_req = 1'b1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c <= 4 && (busy !== 1'b1 || rf_wr_en !== 1'b0)) bz = 1'b0;
      if (irq_ack === 1'b1) lat = c;
    end
    irq_req = 1'b0;
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL save_latency got=%0d exp=5", lat); end
    n_cmp++; if (!bz) begin n_err++; $display("FAIL save_busy got=0 exp=1 in cycles 1-4"); end
    sb.push_back(cur);
    @(posedge clk); #1;
    n_cmp++; if (irq_ack !== 1'b0 || busy !== 1'b0 || depth !== exp_depth) begin
      n_err++; $display("FAIL save_end ack=%b busy=%b depth=%0d exp 0/0/%0d", irq_ack, busy, depth, exp_depth);
    end
  endtask

  task automatic do_restore(input logic [1:0] exp_depth);
    int lat = 0;
    logic [31:0] exp;
    @(negedge clk); iret_req = 1'b1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (iret_ack === 1'b1) lat = c;
    end
    iret_req = 1'b0;
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL iret_latency got=%0d exp=5", lat); end
    @(posedge clk); #1;
    exp = (sb.size() > 0) ? sb.pop_back() : 32'hxxxxxxxx;
    n_cmp++; if (rf_pack() !== exp) begin n_err++; $display("FAIL restore_data got=%h exp=%h", rf_pack(), exp); end
    n_cmp++; if (depth !== exp_depth || iret_ack !== 1'b0) begin
      n_err++; $display("FAIL restore_end depth=%0d ack=%b exp %0d/0", depth, iret_ack, exp_depth);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_req = 0; iret_req = 0; cpu_wr_en = 0;
    cpu_rd1_idx = 0; cpu_rd2_idx = 0; cpu_wr_idx = 0; cpu_wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, irq_ack, iret_ack, iret_err, stack_full, depth} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=0000000", {busy, irq_ack, iret_ack, iret_err, stack_full, depth});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    cpu_rd1_idx = 2'd3; cpu_rd2_idx = 2'd1; cpu_wr_idx = 2'd2; cpu_wr_en = 1'b1; cpu_wr_data = 8'h5A;
    #1;
    n_cmp++; if ({rf_rd1_idx, rf_rd2_idx, rf_wr_idx, rf_wr_en, rf_wr_data} !== {2'd3, 2'd1, 2'd2, 1'b1, 8'h5A}) begin
      n_err++; $display("FAIL passthrough got=%b exp=%b", {rf_rd1_idx, rf_rd2_idx, rf_wr_idx, rf_wr_en, rf_wr_data},
                        {2'd3, 2'd1, 2'd2, 1'b1, 8'h5A});
    end
    @(negedge clk); cpu_wr_en = 1'b0; cpu_rd1_idx = 0;
  endtask

  task automatic test_save_restore();
    load4(32'hFFAA0305);
    do_save(2'd1);
    load4(32'h00000000);
    n_cmp++; if (rf_pack() !== 32'h0) begin n_err++; $display("FAIL cpu_clear got=%h exp=00000000", rf_pack()); end
    do_restore(2'd0);
  endtask

  task automatic test_nested_full();
    bit bad = 1'b0;
    load4(32'h44332211);
    do_save(2'd1);
    load4(32'hDDCCBBAA);
    do_save(2'd2);
    n_cmp++; if (stack_full !== 1'b1) begin n_err++; $display("FAIL stack_full got=%b exp=1", stack_full); end
    @(negedge clk); irq_req = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (irq_ack !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
    irq_req = 1'b0;
    n_cmp++; if (bad || depth !== 2'd2) begin n_err++; $display("FAIL full_irq_ignored bad=%b depth=%0d exp 0/2", bad, depth); end
    load4(32'h00000000);
    do_restore(2'd1);
    do_restore(2'd0);
  endtask

  task automatic test_iret_err();
    int w0;
    logic e1, e2, b1;
    @(negedge clk); w0 = wr_cnt; iret_req = 1'b1;
    @(posedge clk); #1; e1 = iret_err; b1 = busy;
    iret_req = 1'b0;
    @(posedge clk); #1; e2 = iret_err;
    n_cmp++; if ({e1, e2, b1} !== 3'b100) begin n_err++; $display("FAIL iret_err_pulse got=%b exp=100", {e1, e2, b1}); end
    n_cmp++; if (wr_cnt != w0) begin n_err++; $display("FAIL iret_err_no_write got=%0d writes exp=0", wr_cnt - w0); end
  endtask

  task automatic test_priority();
    int lat = 0;
    bit saw_irq = 1'b0;
    logic [31:0] exp;
    load4(32'h0F0E0D0C);
    do_save(2'd1);
    load4(32'h99887766);
    @(negedge clk); irq_req = 1'b1; iret_req = 1'b1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (irq_ack === 1'b1) saw_irq = 1'b1;
      if (iret_ack === 1'b1) lat = c;
    end
    irq_req = 1'b0; iret_req = 1'b0;
    n_cmp++; if (lat != 5 || saw_irq) begin n_err++; $display("FAIL priority lat=%0d irq_ack_seen=%b exp 5/0", lat, saw_irq); end
    @(posedge clk); #1;
    exp = (sb.size() > 0) ? sb.pop_back() : 32'hxxxxxxxx;
    n_cmp++; if (rf_pack() !== exp || depth !== 2'd0) begin
      n_err++; $display("FAIL priority_restore got=%h/%0d exp=%h/0", rf_pack(), depth, exp);
    end
  endtask

  task automatic test_reset_mid_save();
    bit bad = 1'b0;
    @(negedge clk); irq_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, irq_ack, depth, stack_full} !== 5'b0) begin
      n_err++; $display("FAIL reset_mid_save got=%b exp=00000", {busy, irq_ack, depth, stack_full});
    end
    irq_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (irq_ack !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
    n_cmp++; if (bad || depth !== 2'd0) begin n_err++; $display("FAIL reset_no_ack bad=%b depth=%0d exp 0/0", bad, depth); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_save_restore();
    test_nested_full();
    test_iret_err();
    test_priority();
    test_reset_mid_save();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ctx_save_sequencer.md
CTX_SAVE_SEQUENCER -- requirements
Module: ctx_save_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the maximum number of nested context frames held.
REQ-002 SHALL have parameter DW, default 8, meaning the register data width.
REQ-003 SHALL have port clk  in  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port irq_req  in  1  level request: save context; held until irq_ack.
REQ-006 SHALL have port iret_req  in  1  level request: restore context; held until iret_ack or iret_err.
REQ-007 SHALL have port cpu_rd1_idx, cpu_rd2_idx, cpu_wr_idx  in  2 each  CPU register-file indices.
REQ-008 SHALL have port cpu_wr_en  in  1  CPU register-file write enable.
REQ-009 SHALL have port cpu_wr_data  in  DW  CPU write data.
REQ-010 SHALL have port rf_rd1_idx, rf_rd2_idx, rf_wr_idx  out  2 each  indices driven to the register file.
REQ-011 SHALL have port rf_wr_en  out  1  register-file write enable.
REQ-012 SHALL have port rf_wr_data  out  DW  register-file write data.
REQ-013 SHALL have port rf_rd1_data  in  DW  combinational read data from the register file port 1.
REQ-014 SHALL have port busy  out  1  high whenever the sequencer owns the register file.
REQ-015 SHALL have ports irq_ack, iret_ack, iret_err  out  1 each  single-cycle completion or error pulses.
REQ-016 SHALL have port stack_full  out  1  high when sp equals DEPTH.
REQ-017 SHALL have port depth  out  clog2(DEPTH+1)  current frame count (sp).

Function
REQ-018 SHALL implement states IDLE, SAVE, SAVE_DONE, RESTORE and RESTORE_DONE.
REQ-019 In IDLE, SHALL pass all cpu_* ports straight to rf_* ports with busy=0.
REQ-020 In any state other than IDLE, SHALL drive busy=1 and force rf_wr_en=0 except for its own restore writes.
REQ-021 In IDLE with iret_req=1, SHALL go to RESTORE if sp>0, else pulse iret_err for one cycle and stay in IDLE.
REQ-022 In IDLE with irq_req=1 and iret_req=0, SHALL go to SAVE if sp<DEPTH, else stay in IDLE with no ack.
REQ-023 iret_req SHALL take priority over irq_req when both are high in IDLE.
REQ-024 In SAVE, SHALL count k=0..3, drive rf_rd1_idx=k, and capture rf_rd1_data into frame[sp][k] on each edge; after k=3, go to SAVE_DONE.
REQ-025 In SAVE_DONE, SHALL increment sp, pulse irq_ack, and return to IDLE.
REQ-026 The latency from irq_req being sampled in IDLE to irq_ack SHALL be exactly 5 cycles.
REQ-027 In RESTORE, SHALL count k=0..3 and drive rf_wr_en=1, rf_wr_idx=k, rf_wr_data=frame[sp-1][k]; after k=3, go to RESTORE_DONE.
REQ-028 In RESTORE_DONE, SHALL decrement sp, pulse iret_ack, and return to IDLE.
REQ-029 Requests arriving in non-IDLE states SHALL be ignored; they are honoured only if still held when the FSM is back in IDLE.
REQ-030 Frames SHALL be LIFO; nested saves SHALL preserve older frames unmodified.
REQ-031 The index counter SHALL be 2 bits and wrap 3->0; no other arithmetic overflow is possible since sp is bounded to 0..DEPTH.

Reset
REQ-032 On reset, SHALL force state=IDLE, k=0, sp=0, busy=0, irq_ack=iret_ack=iret_err=0, stack_full=0, depth=0.
REQ-033 Reset mid-SAVE or mid-RESTORE SHALL abort the operation with no ack; partially written RF contents are left as-is.
REQ-034 Frame storage SHALL NOT require reset; its contents are don't-care while sp=0.

Structure
REQ-035 Package ctx_pkg SHALL hold the state enum, NUM_REGS=4, and the index width 2.
REQ-036 Frame storage SHALL be the sub-module ctx_stack, with a DEPTH x 4 x DW array, a synchronous write port, and a combinational read port.
REQ-037 The FSM, the k counter and sp SHALL reside in ctx_save_sequencer.

Verification
REQ-038 Preload R0..R3=05,03,AA,FF, pulse irq_req -> irq_ack at cycle 5, depth=1, busy high for cycles 1-4.
REQ-039 After REQ-038, the CPU writes R0..R3=00 and then raises iret_req -> iret_ack 5 cycles later, R0..R3=05,03,AA,FF, depth=0.
REQ-040 Perform two nested saves with differing values, then two irets -> values are restored in LIFO order; stack_full=1 after the second save.
REQ-041 With stack_full=1, assert irq_req -> no irq_ack and state stays IDLE; with sp=0, assert iret_req -> one-cycle iret_err with no RF write.
REQ-042 Assert irq_req and iret_req together with sp=1 -> restore runs first; assert reset during SAVE k=2 -> IDLE, depth=0, no ack.
